// File: rtl/multicycle_controller_if.sv
// Handshake/control bundle between the multi-cycle controller and the shared datapath.
// The controller takes the master modport; the datapath (or a bench) takes the slave modport.
interface multicycle_controller_if #(
    parameter int COUNT_W = 16
);
    logic               start;
    logic [31:0]        instr;
    logic               mem_ready;

    logic [2:0]         stage;
    logic [1:0]         alu_op;
    logic [5:0]         alu_funct;
    logic               ALU_Src;
    logic               mem_read;
    logic               mem_write;
    logic               ir_write;
    logic               pc_write;
    logic               branch;
    logic               reg_write;
    logic               mem_to_reg;
    logic               halted;
    logic [COUNT_W-1:0] instr_count;

    modport master (
        input  start, instr, mem_ready,
        output stage, alu_op, alu_funct, ALU_Src, mem_read, mem_write, ir_write,
               pc_write, branch, reg_write, mem_to_reg, halted, instr_count
    );

    modport slave (
        output start, instr, mem_ready,
        input  stage, alu_op, alu_funct, ALU_Src, mem_read, mem_write, ir_write,
               pc_write, branch, reg_write, mem_to_reg, halted, instr_count
    );
endinterface

// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/exec/mem/writeback, counts retired
// instructions and parks in HALT. The bound interface must use the same COUNT_W.
module multicycle_controller #(
    parameter int         COUNT_W  = 16,
    parameter logic [5:0] HALT_OPC = 6'b111111
) (
    input  logic                   clock,
    input  logic                   reset_n,
    multicycle_controller_if.master bus
);
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_IDLE   = 3'd6,
        S_HALT   = 3'd7
    } state_t;

    localparam logic [5:0] OPC_R    = 6'b000000;
    localparam logic [5:0] OPC_LW   = 6'b100011;
    localparam logic [5:0] OPC_SW   = 6'b101011;
    localparam logic [5:0] OPC_BEQ  = 6'b000100;
    localparam logic [5:0] OPC_ADDI = 6'b001000;

    state_t               r_state;
    logic [5:0]           r_opcode;
    logic [5:0]           r_funct;
    logic [COUNT_W-1:0]   r_count;
    logic [1:0]           r_alu_op;
    logic                 r_alu_src;
    logic                 r_mem_read;
    logic                 r_mem_write;
    logic                 r_branch;
    logic                 r_reg_write;
    logic                 r_mem_to_reg;
    logic                 r_halted;

    state_t               w_state_nxt;
    logic [5:0]           w_opc_nxt;
    logic [5:0]           w_fn_nxt;
    logic                 w_retire;
    logic                 w_supported;
    logic                 w_fetch_done;
    logic                 w_unused;

    // Only the opcode and funct fields steer control; the rest belongs to the datapath.
    assign w_unused     = ^bus.instr[25:6];
    assign w_fetch_done = (r_state == S_FETCH) && bus.mem_ready;
    assign w_supported  = (r_opcode == OPC_R)  || (r_opcode == OPC_LW)  ||
                          (r_opcode == OPC_SW) || (r_opcode == OPC_BEQ) ||
                          (r_opcode == OPC_ADDI);

    always_comb begin
        w_state_nxt = r_state;
        w_opc_nxt   = r_opcode;
        w_fn_nxt    = r_funct;
        w_retire    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) w_state_nxt = S_FETCH;
            end
            S_FETCH: begin
                if (bus.mem_ready) begin
                    w_state_nxt = S_DECODE;
                    w_opc_nxt   = bus.instr[31:26];
                    w_fn_nxt    = bus.instr[5:0];
                end
            end
            S_DECODE: begin
                // HALT wins even if a build maps HALT_OPC onto a supported opcode.
                if (r_opcode == HALT_OPC) begin
                    w_state_nxt = S_HALT;
                end else if (w_supported) begin
                    w_state_nxt = S_EXEC;
                end else begin
                    w_state_nxt = S_FETCH;
                    w_retire    = 1'b1;
                end
            end
            S_EXEC: begin
                if (r_opcode == OPC_BEQ) begin
                    w_state_nxt = S_FETCH;
                    w_retire    = 1'b1;
                end else if ((r_opcode == OPC_LW) || (r_opcode == OPC_SW)) begin
                    w_state_nxt = S_MEM;
                end else begin
                    w_state_nxt = S_WB;
                end
            end
            S_MEM: begin
                if (bus.mem_ready) begin
                    if (r_opcode == OPC_LW) begin
                        w_state_nxt = S_WB;
                    end else begin
                        w_state_nxt = S_FETCH;
                        w_retire    = 1'b1;
                    end
                end
            end
            S_WB: begin
                w_state_nxt = S_FETCH;
                w_retire    = 1'b1;
            end
            S_HALT: begin
                w_state_nxt = S_HALT;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Moore outputs are computed from the next state so they are valid from the first
    // cycle of each state without a combinational decode on the output pins.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_opcode     <= 6'd0;
            r_funct      <= 6'd0;
            r_count      <= '0;
            r_alu_op     <= 2'b00;
            r_alu_src    <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_branch     <= 1'b0;
            r_reg_write  <= 1'b0;
            r_mem_to_reg <= 1'b0;
            r_halted     <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_opcode <= w_opc_nxt;
            r_funct  <= w_fn_nxt;
            if (w_retire) r_count <= r_count + {{(COUNT_W-1){1'b0}}, 1'b1};

            r_mem_read   <= (w_state_nxt == S_FETCH) ||
                            ((w_state_nxt == S_MEM) && (w_opc_nxt == OPC_LW));
            r_mem_write  <= (w_state_nxt == S_MEM) && (w_opc_nxt == OPC_SW);
            r_branch     <= (w_state_nxt == S_EXEC) && (w_opc_nxt == OPC_BEQ);
            r_reg_write  <= (w_state_nxt == S_WB);
            r_mem_to_reg <= (w_state_nxt == S_WB) && (w_opc_nxt == OPC_LW);
            r_alu_src    <= (w_state_nxt == S_EXEC) &&
                            ((w_opc_nxt == OPC_LW) || (w_opc_nxt == OPC_SW) ||
                             (w_opc_nxt == OPC_ADDI));
            if (w_state_nxt == S_EXEC) begin
                if (w_opc_nxt == OPC_R)        r_alu_op <= 2'b10;
                else if (w_opc_nxt == OPC_BEQ) r_alu_op <= 2'b01;
                else                           r_alu_op <= 2'b00;
            end else begin
                r_alu_op <= 2'b00;
            end
            r_halted <= r_halted | (w_state_nxt == S_HALT);
        end
    end

    assign bus.stage       = r_state;
    assign bus.alu_op      = r_alu_op;
    assign bus.alu_funct   = r_funct;
    assign bus.ALU_Src     = r_alu_src;
    assign bus.mem_read    = r_mem_read;
    assign bus.mem_write   = r_mem_write;
    assign bus.branch      = r_branch;
    assign bus.reg_write   = r_reg_write;
    assign bus.mem_to_reg  = r_mem_to_reg;
    assign bus.halted      = r_halted;
    assign bus.instr_count = r_count;
    // IR/PC load is the one Mealy path: it completes in the same cycle memory answers.
    assign bus.ir_write    = w_fetch_done;
    assign bus.pc_write    = w_fetch_done;
endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: per-cycle expectations are queued as each
// instruction is issued, then popped and compared as the controller steps through it.
module tb_multicycle_controller;
    localparam int CW = 4;

    // ctl vector: {mem_read, mem_write, ir_write, pc_write, branch, reg_write,
    //              mem_to_reg, ALU_Src, alu_op[1:0], halted}
    localparam logic [10:0] C_MRD  = 11'h400;
    localparam logic [10:0] C_MWR  = 11'h200;
    localparam logic [10:0] C_IRPC = 11'h180;
    localparam logic [10:0] C_BR   = 11'h040;
    localparam logic [10:0] C_RW   = 11'h020;
    localparam logic [10:0] C_M2R  = 11'h010;
    localparam logic [10:0] C_SRC  = 11'h008;
    localparam logic [10:0] C_OP10 = 11'h004;
    localparam logic [10:0] C_OP01 = 11'h002;
    localparam logic [10:0] C_HLT  = 11'h001;

    logic clock = 1'b0;
    logic reset_n;
    always #5 clock = ~clock;

    multicycle_controller_if #(.COUNT_W(CW)) bus ();

    multicycle_controller #(.COUNT_W(CW), .HALT_OPC(6'b111111)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    logic [10:0] w_ctl;
    assign w_ctl = {bus.mem_read, bus.mem_write, bus.ir_write, bus.pc_write, bus.branch,
                    bus.reg_write, bus.mem_to_reg, bus.ALU_Src, bus.alu_op, bus.halted};

    typedef struct {
        logic          st;
        logic          mr;
        logic [31:0]   ins;
        logic [2:0]    stage;
        logic [10:0]   ctl;
        logic [CW-1:0] cnt;
        logic [5:0]    fn;
    } exp_t;

    exp_t          q[$];
    logic [CW-1:0] m_cnt;
    logic [5:0]    m_fn;
    int            n_chk  = 0;
    int            n_pass = 0;

    task automatic push(input logic st, input logic mr, input logic [31:0] ins,
                        input logic [2:0] stg, input logic [10:0] ctl);
        exp_t e;
        e.st = st; e.mr = mr; e.ins = ins; e.stage = stg; e.ctl = ctl;
        e.cnt = m_cnt; e.fn = m_fn;
        q.push_back(e);
    endtask

    function automatic logic rnd();
        return logic'($urandom_range(0, 1));
    endfunction

    // Expected cycle-by-cycle trace of one instruction, with optional memory stalls.
    task automatic push_instr(input logic [31:0] ins, input int fstall, input int mstall);
        logic [5:0] opc;
        opc = ins[31:26];
        for (int i = 0; i < fstall; i++) push(1'b0, 1'b0, ins, 3'd0, C_MRD);
        push(1'b0, 1'b1, ins, 3'd0, C_MRD | C_IRPC);
        m_fn = ins[5:0];
        push(1'b0, rnd(), ins, 3'd1, 11'h000);
        if (opc == 6'h3F) return;
        if (!(opc == 6'h00 || opc == 6'h23 || opc == 6'h2B || opc == 6'h04 || opc == 6'h08)) begin
            m_cnt++;
            return;
        end
        case (opc)
            6'h00:   push(1'b0, rnd(), ins, 3'd2, C_OP10);
            6'h04:   push(1'b0, rnd(), ins, 3'd2, C_BR | C_OP01);
            default: push(1'b0, rnd(), ins, 3'd2, C_SRC);
        endcase
        if (opc == 6'h04) begin
            m_cnt++;
            return;
        end
        if (opc == 6'h23 || opc == 6'h2B) begin
            for (int i = 0; i <= mstall; i++)
                push(1'b0, (i == mstall), ins, 3'd3, (opc == 6'h23) ? C_MRD : C_MWR);
            if (opc == 6'h2B) begin
                m_cnt++;
                return;
            end
        end
        push(1'b0, rnd(), ins, 3'd4, (opc == 6'h23) ? (C_RW | C_M2R) : C_RW);
        m_cnt++;
    endtask

    task automatic drain(input int n, input string tag);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e = q.pop_front();
            bus.start = e.st; bus.mem_ready = e.mr; bus.instr = e.ins;
            #1;
            n_chk++;
            if (bus.stage !== e.stage || w_ctl !== e.ctl || bus.instr_count !== e.cnt ||
                bus.alu_funct !== e.fn)
                $display("FAIL %s cyc%0d: got stage=%0d ctl=%b cnt=%0d fn=%b, want stage=%0d ctl=%b cnt=%0d fn=%b",
                         tag, i, bus.stage, w_ctl, bus.instr_count, bus.alu_funct,
                         e.stage, e.ctl, e.cnt, e.fn);
            else n_pass++;
            @(posedge clock); #2;
        end
    endtask

    task automatic release_reset();
        @(negedge clock) reset_n = 1'b1;
        @(posedge clock); #2;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; bus.start = 1'b0; bus.mem_ready = 1'b0; bus.instr = 32'd0;
        m_cnt = '0; m_fn = 6'd0;
        #12;
        n_chk++;
        if (bus.stage !== 3'd6 || w_ctl !== 11'h000 || bus.instr_count !== '0 || bus.alu_funct !== 6'd0)
            $display("FAIL reset_state: got stage=%0d ctl=%b cnt=%0d fn=%b, want stage=6 ctl=0 cnt=0 fn=0",
                     bus.stage, w_ctl, bus.instr_count, bus.alu_funct);
        else n_pass++;
        release_reset();
        // Idle without start must hold IDLE.
        push(1'b0, 1'b1, 32'd0, 3'd6, 11'h000);
        push(1'b0, 1'b0, 32'd0, 3'd6, 11'h000);
        drain(q.size(), "idle_hold");
    endtask

    task automatic test_rtype();
        push(1'b1, 1'b0, 32'd0, 3'd6, 11'h000);
        push_instr(32'h012A4020, 0, 0);
        drain(q.size(), "rtype");
        n_chk++;
        if (bus.instr_count !== 4'd1)
            $display("FAIL rtype_count: got %0d want 1", bus.instr_count);
        else n_pass++;
    endtask

    task automatic test_lw_stall();
        push_instr(32'h8D090004, 0, 3);
        if (q.size() != 8) begin
            n_chk++;
            $display("FAIL lw_len: got %0d cycles want 8", q.size());
        end
        drain(q.size(), "lw_stall");
    endtask

    task automatic test_back_to_back();
        push_instr(32'h11090002, 0, 0);   // beq
        push_instr(32'h21290001, 2, 0);   // addi with fetch stall
        push_instr(32'hAD090004, 1, 2);   // sw with both stalls
        push_instr(32'h012A4022, 0, 0);   // sub
        drain(q.size(), "b2b");
    endtask

    task automatic test_reset_mid();
        push_instr(32'h8D090004, 0, 0);
        drain(2, "rst_mid_pre");
        n_chk++;
        if (bus.stage !== 3'd2)
            $display("FAIL rst_mid_exec: got stage=%0d want 2", bus.stage);
        else n_pass++;
        #2 reset_n = 1'b0;
        #1;
        n_chk++;
        if (bus.stage !== 3'd6 || w_ctl !== 11'h000 || bus.instr_count !== '0)
            $display("FAIL rst_mid_async: got stage=%0d ctl=%b cnt=%0d, want stage=6 ctl=0 cnt=0",
                     bus.stage, w_ctl, bus.instr_count);
        else n_pass++;
        q.delete();
        m_cnt = '0; m_fn = 6'd0;
        release_reset();
        push(1'b1, 1'b0, 32'd0, 3'd6, 11'h000);
        push_instr(32'h012A4020, 0, 0);
        drain(q.size(), "rst_restart");
    endtask

    task automatic test_nop_halt();
        push_instr(32'h3C010001, 0, 0);   // unsupported opcode: NOP
        push_instr(32'hFC000000, 0, 0);
        for (int i = 0; i < 4; i++) push(logic'(i % 2 == 0), rnd(), 32'd0, 3'd7, C_HLT);
        drain(q.size(), "nop_halt");
        n_chk++;
        if (bus.halted !== 1'b1 || bus.instr_count !== 4'd2)
            $display("FAIL halt_final: got halted=%b cnt=%0d want halted=1 cnt=2",
                     bus.halted, bus.instr_count);
        else n_pass++;
    endtask

    task automatic test_wrap();
        reset_n = 1'b0;
        m_cnt = '0; m_fn = 6'd0;
        #1;
        release_reset();
        push(1'b1, 1'b0, 32'd0, 3'd6, 11'h000);
        for (int i = 0; i < 16; i++) push_instr(32'hAD090004 + i, 0, 0);
        drain(q.size(), "wrap");
        n_chk++;
        if (bus.instr_count !== 4'd0 || bus.halted !== 1'b0)
            $display("FAIL wrap_final: got cnt=%0d halted=%b want cnt=0 halted=0",
                     bus.instr_count, bus.halted);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_lw_stall();
        test_back_to_back();
        test_reset_mid();
        test_nop_halt();
        test_wrap();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
